// File: rtl/lc3_datapath_mc_if.sv
// Memory handshake bundle between the datapath (master) and the memory model (slave).
interface lc3_datapath_mc_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/lc3_datapath_mc.sv
// Multi-cycle LC-3 style datapath: register file, PC/IR/MAR/MDR, EAB, ALU, priority bus
// and a req/ready memory handshake FSM.
module lc3_datapath_mc #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int RA   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enaMDR,
  input  logic             enaPC,
  input  logic             enaALU,
  input  logic             enaMARM,
  input  logic             ldPC,
  input  logic             ldIR,
  input  logic             ldMAR,
  input  logic             ldMDR,
  input  logic             regWE,
  input  logic             flagWE,
  input  logic             selEAB1,
  input  logic [1:0]       selEAB2,
  input  logic             selMAR,
  input  logic [1:0]       selPC,
  input  logic [2:0]       aluControl,
  input  logic [RA-1:0]    SR1,
  input  logic [RA-1:0]    SR2,
  input  logic [RA-1:0]    DR,
  input  logic             memRd,
  input  logic             memWr,
  lc3_datapath_mc_if.master mem,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             bus_conflict,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic [WIDTH-1:0] IR
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} mem_state_t;

  mem_state_t       state_reg, state_next;
  logic             we_reg, we_next;
  logic [WIDTH-1:0] pc_reg, ir_reg, mar_reg, mdr_reg;
  logic [WIDTH-1:0] rf_reg [NREG];
  logic             n_reg, z_reg, p_reg, conflict_reg;

  logic [WIDTH-1:0] sr1_val, sr2_val, alu_b, alu_out;
  logic [WIDTH-1:0] eab_off, eab, marm, bus;
  logic [2:0]       ena_count;
  logic             read_hit;

  assign sr1_val = rf_reg[SR1];
  assign sr2_val = rf_reg[SR2];

  always_comb begin
    eab_off = '0;
    case (selEAB2)
      2'd1:    eab_off = {{(WIDTH-6){ir_reg[5]}}, ir_reg[5:0]};
      2'd2:    eab_off = {{(WIDTH-9){ir_reg[8]}}, ir_reg[8:0]};
      2'd3:    eab_off = {{(WIDTH-11){ir_reg[10]}}, ir_reg[10:0]};
      default: eab_off = '0;
    endcase
  end

  assign eab   = (selEAB1 ? sr1_val : pc_reg) + eab_off;
  assign marm  = selMAR ? {{(WIDTH-8){1'b0}}, ir_reg[7:0]} : eab;
  assign alu_b = ir_reg[5] ? {{(WIDTH-5){ir_reg[4]}}, ir_reg[4:0]} : sr2_val;

  always_comb begin
    alu_out = sr1_val;
    case (aluControl)
      3'd0:    alu_out = sr1_val + alu_b;
      3'd1:    alu_out = sr1_val & alu_b;
      3'd2:    alu_out = ~sr1_val;
      3'd4:    alu_out = {sr1_val[WIDTH-2:0], 1'b0};
      3'd5:    alu_out = {sr1_val[WIDTH-1], sr1_val[WIDTH-1:1]};
      default: alu_out = sr1_val;
    endcase
  end

  // Fixed priority MDR > PC > ALU > MARM; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (enaMDR)       bus = mdr_reg;
    else if (enaPC)   bus = pc_reg;
    else if (enaALU)  bus = alu_out;
    else if (enaMARM) bus = marm;
  end

  assign ena_count = 3'(enaMDR) + 3'(enaPC) + 3'(enaALU) + 3'(enaMARM);
  assign read_hit  = (state_reg == ST_REQ) && mem.mem_ready && !we_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
    end
  end

  // Start pulses only count in IDLE; read wins when both are raised together.
  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    case (state_reg)
      ST_IDLE: begin
        if (memRd) begin
          state_next = ST_REQ;
          we_next    = 1'b0;
        end else if (memWr) begin
          state_next = ST_REQ;
          we_next    = 1'b1;
        end
      end
      ST_REQ:  if (mem.mem_ready) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= '0;
      ir_reg       <= '0;
      mar_reg      <= '0;
      mdr_reg      <= '0;
      n_reg        <= 1'b0;
      z_reg        <= 1'b0;
      p_reg        <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      if (ldPC) begin
        case (selPC)
          2'd0:    pc_reg <= pc_reg + WIDTH'(1);
          2'd1:    pc_reg <= eab;
          2'd2:    pc_reg <= bus;
          default: pc_reg <= pc_reg;
        endcase
      end
      if (ldIR)  ir_reg  <= bus;
      if (ldMAR) mar_reg <= bus;
      if (read_hit)   mdr_reg <= mem.mem_rdata;
      else if (ldMDR) mdr_reg <= bus;
      if (flagWE) begin
        n_reg <= bus[WIDTH-1];
        z_reg <= (bus == '0);
        p_reg <= !bus[WIDTH-1] && (bus != '0);
      end
      if (ena_count > 3'd1) conflict_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (regWE) begin
      rf_reg[DR] <= bus;
    end
  end

  assign mem.mem_req   = (state_reg == ST_REQ);
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = mar_reg;
  assign mem.mem_wdata = mdr_reg;
  assign mem_busy      = (state_reg != ST_IDLE);
  assign mem_done      = (state_reg == ST_DONE);
  assign bus_conflict  = conflict_reg;
  assign N             = n_reg;
  assign Z             = z_reg;
  assign P             = p_reg;
  assign IR            = ir_reg;

endmodule

// File: tb/tb_lc3_datapath_mc.sv
// Directed bench: a table of single-cycle control vectors plus hand-written memory sequences.
module tb_lc3_datapath_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enaMDR, enaPC, enaALU, enaMARM;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
  logic        selEAB1, selMAR;
  logic [1:0]  selEAB2, selPC;
  logic [2:0]  aluControl;
  logic [3:0]  SR1, SR2, DR;
  logic        memRd, memWr, mem_ready;
  logic [31:0] mem_rdata;

  logic        busy16, done16, conf16, n16, z16, p16;
  logic [15:0] ir16;
  logic        busy32, done32, conf32, n32, z32, p32;
  logic [31:0] ir32;

  int tests = 0;
  int fails = 0;

  lc3_datapath_mc_if #(.WIDTH(16)) mif16 ();
  lc3_datapath_mc_if #(.WIDTH(32)) mif32 ();

  assign mif16.mem_ready = mem_ready;
  assign mif16.mem_rdata = mem_rdata[15:0];
  assign mif32.mem_ready = mem_ready;
  assign mif32.mem_rdata = mem_rdata;

  lc3_datapath_mc #(.WIDTH(16), .NREG(8)) u_dut (
    .clk(clk), .rst(rst),
    .enaMDR(enaMDR), .enaPC(enaPC), .enaALU(enaALU), .enaMARM(enaMARM),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .regWE(regWE), .flagWE(flagWE),
    .selEAB1(selEAB1), .selEAB2(selEAB2), .selMAR(selMAR), .selPC(selPC),
    .aluControl(aluControl), .SR1(SR1[2:0]), .SR2(SR2[2:0]), .DR(DR[2:0]),
    .memRd(memRd), .memWr(memWr), .mem(mif16),
    .mem_busy(busy16), .mem_done(done16), .bus_conflict(conf16),
    .N(n16), .Z(z16), .P(p16), .IR(ir16)
  );

  lc3_datapath_mc #(.WIDTH(32), .NREG(16)) u_dut32 (
    .clk(clk), .rst(rst),
    .enaMDR(enaMDR), .enaPC(enaPC), .enaALU(enaALU), .enaMARM(enaMARM),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .regWE(regWE), .flagWE(flagWE),
    .selEAB1(selEAB1), .selEAB2(selEAB2), .selMAR(selMAR), .selPC(selPC),
    .aluControl(aluControl), .SR1(SR1), .SR2(SR2), .DR(DR),
    .memRd(memRd), .memWr(memWr), .mem(mif32),
    .mem_busy(busy32), .mem_done(done32), .bus_conflict(conf32),
    .N(n32), .Z(z32), .P(p32), .IR(ir32)
  );

  typedef struct {
    logic [3:0]  ena;   // {MDR, PC, ALU, MARM}
    logic [5:0]  ld;    // {ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE}
    logic        e1;
    logic [1:0]  e2;
    logic        sm;
    logic [1:0]  sp;
    logic [2:0]  alu;
    logic [3:0]  sr1, sr2, dr;
    logic        pre;
    logic [15:0] pv;
    logic [15:0] mar, mdr, ir;
    logic [2:0]  nzp;
    logic        conf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] ena, input logic [5:0] ld, input logic e1,
                     input logic [1:0] e2, input logic sm, input logic [1:0] sp,
                     input logic [2:0] alu, input logic [3:0] sr1, input logic [3:0] sr2,
                     input logic [3:0] dr, input logic pre, input logic [15:0] pv,
                     input logic [15:0] mar, input logic [15:0] mdr, input logic [15:0] ir,
                     input logic [2:0] nzp, input logic conf);
    vec_t v;
    v.ena = ena; v.ld = ld; v.e1 = e1; v.e2 = e2; v.sm = sm; v.sp = sp; v.alu = alu;
    v.sr1 = sr1; v.sr2 = sr2; v.dr = dr; v.pre = pre; v.pv = pv;
    v.mar = mar; v.mdr = mdr; v.ir = ir; v.nzp = nzp; v.conf = conf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic [3:0] ena, input logic [5:0] ld, input logic e1,
                          input logic [1:0] e2, input logic sm, input logic [1:0] sp,
                          input logic [2:0] alu, input logic [3:0] sr1, input logic [3:0] sr2,
                          input logic [3:0] dr);
    {enaMDR, enaPC, enaALU, enaMARM} = ena;
    {ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE} = ld;
    selEAB1 = e1; selEAB2 = e2; selMAR = sm; selPC = sp;
    aluControl = alu; SR1 = sr1; SR2 = sr2; DR = dr;
  endtask

  task automatic clear_ctrl();
    set_ctrl(4'b0, 6'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read transaction through the memory port; leaves both FSMs back in IDLE.
  task automatic do_read(input logic [31:0] val);
    int n;
    memRd = 1'b1;
    tick();
    memRd = 1'b0;
    n = 0;
    while (mif16.mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) begin tests++; fails++; $display("FAIL rd_req_timeout: got no mem_req"); end
    mem_rdata = val;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n = 0;
    while (done16 !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) begin tests++; fails++; $display("FAIL rd_done_timeout: got no mem_done"); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; memRd = 1'b0; memWr = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    clear_ctrl();

    //   ena      ld        e1 e2 sm sp alu sr1 sr2 dr pre pv        mar       mdr       ir        nzp     c
    add(4'b0100, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0);
    add(4'b0100, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 3'b000, 0);
    add(4'b0100, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 3'b000, 0);
    add(4'b0100, 6'b101000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 3'b000, 0);
    add(4'b0100, 6'b101000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 3'b000, 0);
    add(4'b1000, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0021, 16'h0003, 16'h0021, 16'h0021, 3'b000, 0);
    add(4'b1000, 6'b000011, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h7FFF, 16'h0003, 16'h7FFF, 16'h0021, 3'b001, 0);
    add(4'b0010, 6'b001011, 0, 0, 0, 0, 0, 1, 0, 2, 0, 16'h0000, 16'h8000, 16'h7FFF, 16'h0021, 3'b100, 0);
    add(4'b0010, 6'b001011, 0, 0, 0, 0, 5, 2, 0, 3, 0, 16'h0000, 16'hC000, 16'h7FFF, 16'h0021, 3'b100, 0);
    add(4'b1000, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 16'hC000, 16'h0020, 16'h0020, 3'b100, 0);
    add(4'b0010, 6'b001011, 0, 0, 0, 0, 1, 3, 0, 4, 0, 16'h0000, 16'h0000, 16'h0020, 16'h0020, 3'b010, 0);
    add(4'b0010, 6'b001001, 0, 0, 0, 0, 2, 3, 0, 0, 0, 16'h0000, 16'h3FFF, 16'h0020, 16'h0020, 3'b001, 0);
    add(4'b0010, 6'b001001, 0, 0, 0, 0, 4, 1, 0, 0, 0, 16'h0000, 16'hFFFE, 16'h0020, 16'h0020, 3'b100, 0);
    add(4'b1000, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 3'b100, 0);
    add(4'b0010, 6'b001001, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h0000, 16'h3FFF, 16'h0000, 16'h0000, 3'b001, 0);
    add(4'b1000, 6'b010000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFF85, 16'h3FFF, 16'hFF85, 16'hFF85, 3'b001, 0);
    add(4'b0001, 6'b001001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0085, 16'hFF85, 16'hFF85, 3'b001, 0);
    add(4'b0001, 6'b001000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0008, 16'hFF85, 16'hFF85, 3'b001, 0);
    add(4'b0001, 6'b001001, 0, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hFF88, 16'hFF85, 16'hFF85, 3'b100, 0);
    add(4'b0001, 6'b101000, 1, 3, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h7F84, 16'hFF85, 16'hFF85, 3'b100, 0);
    add(4'b0100, 6'b101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h7F84, 16'hFF85, 16'hFF85, 3'b100, 0);
    add(4'b0010, 6'b101100, 0, 0, 0, 2, 3, 2, 0, 0, 0, 16'h0000, 16'h8000, 16'h8000, 16'hFF85, 3'b100, 0);
    add(4'b0100, 6'b001000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h8000, 16'h8000, 16'hFF85, 3'b100, 0);
    add(4'b0010, 6'b000101, 0, 0, 0, 0, 7, 4, 0, 0, 0, 16'h0000, 16'h8000, 16'h0000, 16'hFF85, 3'b010, 0);
    add(4'b0110, 6'b001001, 0, 0, 0, 0, 3, 1, 0, 0, 0, 16'h0000, 16'h8000, 16'h0000, 16'hFF85, 3'b100, 1);
    add(4'b0000, 6'b001001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFF85, 3'b010, 1);
    add(4'b0011, 6'b001000, 0, 0, 1, 0, 6, 1, 0, 0, 0, 16'h0000, 16'h7FFF, 16'h0000, 16'hFF85, 3'b010, 1);
    add(4'b1000, 6'b000010, 0, 0, 0, 0, 0, 0, 0, 5, 1, 16'h1234, 16'h7FFF, 16'h1234, 16'hFF85, 3'b010, 1);
    add(4'b0010, 6'b001000, 0, 0, 0, 0, 3, 5, 0, 0, 0, 16'h0000, 16'h1234, 16'h1234, 16'hFF85, 3'b010, 1);

    // Reset state
    tick();
    tick();
    check("rst_req", mif16.mem_req, 1'b0);
    check("rst_busy", busy16, 1'b0);
    check("rst_done", done16, 1'b0);
    check("rst_addr", mif16.mem_addr, 16'h0);
    check("rst_wdata", mif16.mem_wdata, 16'h0);
    check("rst_nzp", {n16, z16, p16}, 3'b000);
    check("rst_ir", ir16, 16'h0);
    check("rst_conf", conf16, 1'b0);
    check("rst_addr32", mif32.mem_addr, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].pre) do_read({16'h0, vecs[i].pv});
      set_ctrl(vecs[i].ena, vecs[i].ld, vecs[i].e1, vecs[i].e2, vecs[i].sm, vecs[i].sp,
               vecs[i].alu, vecs[i].sr1, vecs[i].sr2, vecs[i].dr);
      tick();
      clear_ctrl();
      $display("[TB] vec %0d mar=%h mdr=%h ir=%h nzp=%b conf=%b", i,
               mif16.mem_addr, mif16.mem_wdata, ir16, {n16, z16, p16}, conf16);
      check($sformatf("v%0d_mar", i), mif16.mem_addr, vecs[i].mar);
      check($sformatf("v%0d_mdr", i), mif16.mem_wdata, vecs[i].mdr);
      check($sformatf("v%0d_ir", i), ir16, vecs[i].ir);
      check($sformatf("v%0d_nzp", i), {n16, z16, p16}, vecs[i].nzp);
      check($sformatf("v%0d_conf", i), conf16, vecs[i].conf);
    end

    // Read with two wait cycles; a memWr during REQ must be ignored
    do_read(32'h0040);
    set_ctrl(4'b1000, 6'b001000, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    clear_ctrl();
    memRd = 1'b1;
    tick();
    memRd = 1'b0;
    check("rd_c1_req", mif16.mem_req, 1'b1);
    check("rd_c1_we", mif16.mem_we, 1'b0);
    check("rd_c1_addr", mif16.mem_addr, 16'h0040);
    check("rd_c1_busy", busy16, 1'b1);
    tick();
    check("rd_c2_req", mif16.mem_req, 1'b1);
    memWr = 1'b1;
    tick();
    memWr = 1'b0;
    check("rd_c3_req", mif16.mem_req, 1'b1);
    check("rd_c3_we", mif16.mem_we, 1'b0);
    check("rd_c3_done", done16, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000BEEF;
    tick();
    mem_ready = 1'b0;
    $display("[TB] read mdr=%h done=%b", mif16.mem_wdata, done16);
    check("rd_c4_done", done16, 1'b1);
    check("rd_c4_req", mif16.mem_req, 1'b0);
    check("rd_c4_mdr", mif16.mem_wdata, 16'hBEEF);
    tick();
    check("rd_c5_done", done16, 1'b0);
    check("rd_c5_busy", busy16, 1'b0);
    check("rd_c5_req", mif16.mem_req, 1'b0);

    // memRd and memWr together: the read wins
    memRd = 1'b1;
    memWr = 1'b1;
    tick();
    memRd = 1'b0;
    memWr = 1'b0;
    check("rw_req", mif16.mem_req, 1'b1);
    check("rw_we", mif16.mem_we, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h00001111;
    tick();
    mem_ready = 1'b0;
    $display("[TB] rd+wr mdr=%h done=%b", mif16.mem_wdata, done16);
    check("rw_done", done16, 1'b1);
    check("rw_mdr", mif16.mem_wdata, 16'h1111);
    tick();

    // Plain write: MDR drives wdata and is not overwritten on completion
    memWr = 1'b1;
    tick();
    memWr = 1'b0;
    check("wr_req", mif16.mem_req, 1'b1);
    check("wr_we", mif16.mem_we, 1'b1);
    check("wr_wdata", mif16.mem_wdata, 16'h1111);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000DEAD;
    tick();
    mem_ready = 1'b0;
    $display("[TB] write wdata=%h done=%b", mif16.mem_wdata, done16);
    check("wr_done", done16, 1'b1);
    check("wr_mdr_kept", mif16.mem_wdata, 16'h1111);
    tick();
    check("wr_idle", busy16, 1'b0);

    // mem_ready while IDLE is ignored
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("idle_rdy_busy", busy16, 1'b0);
    check("idle_rdy_done", done16, 1'b0);

    // Reset in the middle of a request aborts it and clears sticky state
    check("pre_rst_conf", conf16, 1'b1);
    memRd = 1'b1;
    tick();
    memRd = 1'b0;
    check("abort_req_before", mif16.mem_req, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    $display("[TB] abort req=%b busy=%b conf=%b", mif16.mem_req, busy16, conf16);
    check("abort_req", mif16.mem_req, 1'b0);
    check("abort_busy", busy16, 1'b0);
    check("abort_done", done16, 1'b0);
    check("abort_mdr", mif16.mem_wdata, 16'h0);
    check("abort_mar", mif16.mem_addr, 16'h0);
    check("abort_conf", conf16, 1'b0);
    check("abort_busy32", busy32, 1'b0);
    tick();
    check("abort_done_after", done16, 1'b0);

    // Wide variant: write R15 and read it back through the ALU
    do_read(32'hCAFEF00D);
    set_ctrl(4'b1000, 6'b000011, 0, 0, 0, 0, 0, 0, 0, 4'd15);
    tick();
    clear_ctrl();
    check("w32_nzp", {n32, z32, p32}, 3'b100);
    set_ctrl(4'b0010, 6'b001000, 0, 0, 0, 0, 3'd3, 4'd15, 0, 0);
    tick();
    clear_ctrl();
    $display("[TB] r15 readback mar32=%h mar16=%h", mif32.mem_addr, mif16.mem_addr);
    check("w32_r15", mif32.mem_addr, 32'hCAFEF00D);
    check("w16_r7", mif16.mem_addr, 16'hF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_datapath_mc.md
# lc3_datapath_mc

Parametrised multi-cycle successor to the LC-3 datapath: same register file, PC, IR, NZP, MAR/MDR and effective-address unit, generalised to WIDTH-bit words and NREG registers. It adds a req/ready memory handshake FSM in place of single-cycle memory, a wider ALU op set, and a priority bus mux with a sticky conflict flag. It sits between the control FSM and the memory model.

## Interface
- WIDTH, 16, datapath word width; legal values are ≥16.
- NREG, 8, register count; a power of two, ≥8. RA = $clog2(NREG).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- enaMDR, enaPC, enaALU, enaMARM  in  1 each  bus source enables.
- ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE  in  1 each  load strobes.
- selEAB1  in  1  EAB base: 0 = PC, 1 = SR1.
- selEAB2  in  2  EAB offset: 0 = zero, 1 = sext(IR[5:0]), 2 = sext(IR[8:0]), 3 = sext(IR[10:0]).
- selMAR  in  1  MARM: 1 = zext(IR[7:0]), 0 = EAB.
- selPC  in  2  0 = PC+1, 1 = EAB, 2 = bus, 3 = hold.
- aluControl  in  3  0 ADD, 1 AND, 2 NOT(SR1), 3 PASS(SR1), 4 SHL1, 5 SRA1, 6/7 PASS.
- SR1, SR2, DR  in  RA each  register selects.
- memRd, memWr  in  1 each  single-cycle memory start pulses.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  MAR.
- mem_wdata  out  WIDTH  MDR.
- mem_rdata  in  WIDTH  read data, valid while mem_ready=1.
- mem_ready  in  1  completes the request.
- mem_busy  out  1  FSM not IDLE.
- mem_done  out  1  one-cycle completion pulse.
- bus_conflict  out  1  sticky; set when more than one bus enable is high in a cycle.
- N, Z, P  out  1 each  condition codes.
- IR  out  WIDTH  instruction register.

## Operation
- Bus priority: MDR > PC > ALU > MARM. With no enable high, the bus is 0.
- ALU operand B = IR[5] ? sext(IR[4:0]) : SR2. All arithmetic is modulo 2^WIDTH. SRA1 replicates the MSB.
- Register reads are combinational. A write to DR at the clock edge is not visible to a same-cycle read.
- NZP on flagWE, from the signed bus value: negative → 100, zero → 010, positive → 001.
- ldMDR loads the bus into MDR. A memory-read completion also loads MDR and takes priority over ldMDR.
- ldPC applies selPC. selPC=3 leaves PC unchanged even when ldPC=1.
- Memory FSM:
  - IDLE: memRd → REQ with mem_we=0. memWr → REQ with mem_we=1. Both high → read wins, write dropped.
  - REQ: mem_req=1, with mem_we, mem_addr and mem_wdata held stable. When mem_ready=1, a read latches mem_rdata into MDR, then → DONE.
  - DONE: mem_done=1 for one cycle, then → IDLE.
  - memRd/memWr outside IDLE are ignored.
- mem_addr and mem_wdata are MAR and MDR directly. The control FSM must not assert ldMAR or ldMDR while mem_busy=1. If it does, the registers still update (no protection).
- bus_conflict is cleared only by reset.

## Timing
- Reset (rst=0 at an edge): PC, IR, MAR, MDR and all registers → 0, NZP → 000, FSM → IDLE, bus_conflict → 0. All outputs read 0 the next cycle.
- Reset mid-transaction aborts it: mem_req drops the next cycle, no mem_done, MDR = 0.
- Minimum access is 3 cycles: the start pulse at edge 0 gives mem_req=1 in cycle 1. mem_ready sampled high at edge k gives mem_done in cycle k+1, and mem_busy=0 in cycle k+2.
- mem_ready while IDLE or DONE is ignored.
- All register loads take effect at the edge where the strobe is sampled, so the new value is visible the next cycle.

## Test plan
- Reset, then enaPC+ldMAR, ldPC with selPC=0 for 3 cycles → PC=3, MAR=2, NZP=000, bus_conflict=0.
- Read: MAR=0x0040, memRd pulse, mem_ready held low for 2 cycles then high with mem_rdata=0xBEEF → mem_req high for 3 cycles, MDR=0xBEEF, mem_done a single pulse.
- Write with memRd and memWr together → read performed (mem_we=0). A memWr during REQ is ignored.
- R1=0x7FFF, IR[5]=1, IR[4:0]=00001, ADD → R2=0x8000, NZP=100. Then SRA1 on R2 → 0xC000. Then AND with imm 0 → 0, NZP=010.
- enaPC and enaALU high together → bus = PC, bus_conflict=1 and stays set until rst=0.
- rst=0 while in REQ → mem_req=0 the next cycle, mem_busy=0, no mem_done. With WIDTH=32, NREG=16, R15 is written and read back correctly.
